// File: rtl/dll_seq_pkg.sv
// Shared encodings, widths and small helpers for the DLL reset/lock sequencer.
package dll_seq_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;
    localparam int FLT_LEN = 16;
    localparam int FLT_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        HOLD = 3'd0,
        RSTD = 3'd1,
        WAIT = 3'd2,
        LOCK = 3'd3,
        FAIL = 3'd4
    } seq_state_e;

    // Saturating retry increment: never passes the configured limit.
    function automatic logic [RETRY_W-1:0] retry_inc(
        input logic [RETRY_W-1:0] cnt,
        input logic [RETRY_W-1:0] lim
    );
        logic [RETRY_W-1:0] res;
        if (cnt >= lim) begin
            res = cnt;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dll_lock_sync.sv
// Two-flop synchroniser bringing the raw DLL LOCKED outputs into the CLKIN domain.
module dll_lock_sync #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of the asynchronous lock inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= {W{1'b0}};
            sync_r <= {W{1'b0}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/dll_rst_seq.sv
// DLL reset/lock sequencer: timed RST pulse, lock wait with timeout, bounded retries.
// Optional lock debounce enabled by defining DLL_LOCK_FILTER_EN.
module dll_rst_seq
    import dll_seq_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int RST_CYC   = 8,
    parameter int LOCK_TO   = 4096,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 13
) (
    input  logic               CLKIN,
    input  logic               rst,
    input  logic [NCH-1:0]     ch_en,
    input  logic               restart,
    input  logic [NCH-1:0]     locked_in,
    output logic [NCH-1:0]     dll_rst,
    output logic               all_locked,
    output logic               fail,
    output logic               lost_lock,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [STATE_W-1:0] state
);

    localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TO - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [NCH-1:0]     ALL_ONES  = {NCH{1'b1}};
    localparam logic [NCH-1:0]     ALL_ZERO  = {NCH{1'b0}};

    logic [NCH-1:0]     lock_s;
    logic               all_ok_s;
    logic               grant_s;
    logic               loss_s;

    seq_state_e         state_r;
    seq_state_e         nxt_state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   nxt_cnt_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] nxt_retry_s;
    logic               lost_r;
    logic               nxt_lost_s;
    logic [NCH-1:0]     ch_en_r;
    logic [NCH-1:0]     dll_rst_r;
    logic               all_locked_r;
    logic               fail_r;

    dll_lock_sync #(
        .W (NCH)
    ) u_sync (
        .clk (CLKIN),
        .rst (rst),
        .d   (locked_in),
        .q   (lock_s)
    );

    assign all_ok_s = ((lock_s & ch_en) == ch_en);

`ifdef DLL_LOCK_FILTER_EN
    localparam logic [FLT_W-1:0] FLT_ZERO = {FLT_W{1'b0}};
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FLT_LEN - 1);

    logic [FLT_W-1:0] flt_r;
    logic [FLT_W-1:0] nxt_flt_s;
    logic             drop_r;
    logic             nxt_drop_s;

    // Lock must hold for the full filter length; a loss must persist two cycles.
    assign grant_s = all_ok_s && (flt_r == FLT_LAST);
    assign loss_s  = !all_ok_s && drop_r;

    // Filter bookkeeping: count consecutive good cycles in WAIT, remember drops in LOCK.
    always_comb begin
        nxt_flt_s  = FLT_ZERO;
        nxt_drop_s = 1'b0;
        if (state_r == WAIT && all_ok_s && !grant_s) begin
            nxt_flt_s = flt_r + 4'd1;
        end else begin
            nxt_flt_s = FLT_ZERO;
        end
        if (state_r == LOCK) begin
            nxt_drop_s = !all_ok_s;
        end else begin
            nxt_drop_s = 1'b0;
        end
    end

    // Filter registers.
    always_ff @(posedge CLKIN or posedge rst) begin
        if (rst) begin
            flt_r  <= FLT_ZERO;
            drop_r <= 1'b0;
        end else begin
            flt_r  <= nxt_flt_s;
            drop_r <= nxt_drop_s;
        end
    end
`else
    assign grant_s = all_ok_s;
    assign loss_s  = !all_ok_s;
`endif

    // Next-state decision: mask-clear, restart and mask-change override the per-state rules.
    always_comb begin
        nxt_state_s = state_r;
        nxt_cnt_s   = cnt_r;
        nxt_retry_s = retry_r;
        nxt_lost_s  = lost_r;
        if (ch_en == ALL_ZERO) begin
            nxt_state_s = HOLD;
            nxt_cnt_s   = CNT_ZERO;
        end else if (restart) begin
            nxt_state_s = RSTD;
            nxt_cnt_s   = CNT_ZERO;
            nxt_retry_s = {RETRY_W{1'b0}};
            nxt_lost_s  = 1'b0;
        end else if (ch_en != ch_en_r) begin
            nxt_state_s = RSTD;
            nxt_cnt_s   = CNT_ZERO;
            nxt_retry_s = {RETRY_W{1'b0}};
        end else begin
            case (state_r)
                HOLD: begin
                    nxt_state_s = RSTD;
                    nxt_cnt_s   = CNT_ZERO;
                end
                RSTD: begin
                    if (cnt_r == RST_LAST) begin
                        nxt_state_s = WAIT;
                        nxt_cnt_s   = CNT_ZERO;
                    end else begin
                        nxt_cnt_s   = cnt_r + CNT_ONE;
                    end
                end
                WAIT: begin
                    // Lock is tested first so it wins over a coincident timeout.
                    if (grant_s) begin
                        nxt_state_s = LOCK;
                        nxt_cnt_s   = CNT_ZERO;
                    end else if (cnt_r == TO_LAST) begin
                        nxt_cnt_s = CNT_ZERO;
                        if (retry_r == RETRY_MAX) begin
                            nxt_state_s = FAIL;
                        end else begin
                            nxt_state_s = RSTD;
                            nxt_retry_s = retry_inc(retry_r, RETRY_MAX);
                        end
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                LOCK: begin
                    nxt_cnt_s = CNT_ZERO;
                    if (loss_s) begin
                        nxt_state_s = RSTD;
                        nxt_lost_s  = 1'b1;
                        nxt_retry_s = {RETRY_W{1'b0}};
                    end else begin
                        nxt_state_s = LOCK;
                    end
                end
                FAIL: begin
                    nxt_cnt_s = CNT_ZERO;
                end
                default: begin
                    nxt_state_s = HOLD;
                    nxt_cnt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Sequencer state and outputs, registered from the decided next state.
    always_ff @(posedge CLKIN or posedge rst) begin
        if (rst) begin
            state_r      <= RSTD;
            cnt_r        <= CNT_ZERO;
            retry_r      <= {RETRY_W{1'b0}};
            lost_r       <= 1'b0;
            ch_en_r      <= ALL_ZERO;
            dll_rst_r    <= ALL_ONES;
            all_locked_r <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            state_r      <= nxt_state_s;
            cnt_r        <= nxt_cnt_s;
            retry_r      <= nxt_retry_s;
            lost_r       <= nxt_lost_s;
            ch_en_r      <= ch_en;
            dll_rst_r    <= (nxt_state_s == WAIT || nxt_state_s == LOCK) ? ~ch_en : ALL_ONES;
            all_locked_r <= (nxt_state_s == LOCK);
            fail_r       <= (nxt_state_s == FAIL);
        end
    end

    assign dll_rst    = dll_rst_r;
    assign all_locked = all_locked_r;
    assign fail       = fail_r;
    assign lost_lock  = lost_r;
    assign retry_cnt  = retry_r;
    assign state      = state_r;

endmodule

// File: tb/tb_dll_rst_seq.sv
// Self-checking bench for dll_rst_seq: directed scenarios plus random stimulus vs. a time-based model.
module tb_dll_rst_seq;

    localparam int NCH       = 2;
    localparam int RST_CYC   = 8;
    localparam int LOCK_TO   = 64;
    localparam int MAX_RETRY = 3;
    localparam int CNT_W     = 13;

    localparam int S_HOLD = 0;
    localparam int S_RSTD = 1;
    localparam int S_WAIT = 2;
    localparam int S_LOCK = 3;
    localparam int S_FAIL = 4;

    logic           CLKIN;
    logic           rst;
    logic [NCH-1:0] ch_en;
    logic           restart;
    logic [NCH-1:0] locked_in;
    logic [NCH-1:0] dll_rst;
    logic           all_locked;
    logic           fail;
    logic           lost_lock;
    logic [3:0]     retry_cnt;
    logic [2:0]     state;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Model: phase, edge index at which it was entered, retries, sticky loss flag.
    int         m_st;
    int         m_t0;
    int         m_cyc = 0;
    int         m_retry;
    bit         m_lost;
    logic [1:0] m_prev_en;
    logic [1:0] m_dll;
    logic [1:0] m_pipe[$];

    dll_rst_seq #(
        .NCH       (NCH),
        .RST_CYC   (RST_CYC),
        .LOCK_TO   (LOCK_TO),
        .MAX_RETRY (MAX_RETRY),
        .CNT_W     (CNT_W)
    ) dut (
        .CLKIN      (CLKIN),
        .rst        (rst),
        .ch_en      (ch_en),
        .restart    (restart),
        .locked_in  (locked_in),
        .dll_rst    (dll_rst),
        .all_locked (all_locked),
        .fail       (fail),
        .lost_lock  (lost_lock),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    initial CLKIN = 1'b0;
    always #5 CLKIN = ~CLKIN;

    task automatic chk_val(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st      = S_RSTD;
        m_retry   = 0;
        m_lost    = 1'b0;
        m_prev_en = 2'b00;
        m_dll     = 2'b11;
        m_pipe    = {2'b00, 2'b00};
        m_t0      = m_cyc - 1;
    endtask

    task automatic m_go(input int s);
        m_st = s;
        m_t0 = m_cyc;
    endtask

    // One clock edge of the model, using the inputs currently applied.
    task automatic model_step();
        logic [1:0] ls;
        bit         ok;
        int         el;
        ls = m_pipe.pop_front();
        m_pipe.push_back(locked_in);
        ok = ((ls & ch_en) == ch_en);
        el = m_cyc - m_t0;
        if (ch_en == 2'b00) begin
            m_go(S_HOLD);
        end else if (restart) begin
            m_go(S_RSTD);
            m_retry = 0;
            m_lost  = 1'b0;
        end else if (ch_en != m_prev_en) begin
            m_go(S_RSTD);
            m_retry = 0;
        end else begin
            case (m_st)
                S_HOLD: m_go(S_RSTD);
                S_RSTD: if (el == RST_CYC) m_go(S_WAIT);
                S_WAIT: begin
                    if (ok) m_go(S_LOCK);
                    else if (el == LOCK_TO) begin
                        if (m_retry == MAX_RETRY) m_go(S_FAIL);
                        else begin
                            m_retry++;
                            m_go(S_RSTD);
                        end
                    end
                end
                S_LOCK: if (!ok) begin
                    m_go(S_RSTD);
                    m_lost  = 1'b1;
                    m_retry = 0;
                end
                default: ;
            endcase
        end
        m_prev_en = ch_en;
        m_dll = (m_st == S_WAIT || m_st == S_LOCK) ? ~ch_en : 2'b11;
        m_cyc++;
    endtask

    task automatic compare_all();
        chk_val("state", state, m_st);
        chk_val("dll_rst", dll_rst, m_dll);
        chk_val("all_locked", all_locked, int'(m_st == S_LOCK));
        chk_val("fail", fail, int'(m_st == S_FAIL));
        chk_val("lost_lock", lost_lock, m_lost);
        chk_val("retry_cnt", retry_cnt, m_retry);
    endtask

    task automatic tick();
        if (rst) begin
            m_cyc++;
            model_reset();
        end else begin
            model_step();
        end
        @(posedge CLKIN);
        #1;
        compare_all();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    initial begin
        int n;
        int run;
        int pulses;
        rst       = 1'b1;
        ch_en     = 2'b11;
        restart   = 1'b0;
        locked_in = 2'b00;
        model_reset();
        repeat (2) tick();
        chk_val("reset_dll_rst", dll_rst, 3);
        chk_val("reset_state", state, S_RSTD);
        rst = 1'b0;

        // Power-up sequence: first edge re-sequences on the mask, then an 8-cycle pulse.
        n = 0;
        while (dll_rst != 2'b00 && n < 40) begin
            tick();
            n++;
        end
        chk_val("first_fall", n, RST_CYC + 1);
        repeat (20) tick();
        locked_in = 2'b11;
        n = 0;
        while (!all_locked && n < 10) begin
            tick();
            n++;
        end
        chk_val("lock_latency", n, 3);
        chk_val("lock_retry", retry_cnt, 0);

        // Loss of lock on channel 1 for five cycles.
        locked_in = 2'b01;
        n = 0;
        while (all_locked && n < 10) begin
            tick();
            n++;
        end
        chk_val("loss_latency", n, 3);
        chk_val("lost_set", lost_lock, 1);
        repeat (2) tick();
        locked_in = 2'b11;
        repeat (30) tick();
        chk_val("relocked", all_locked, 1);
        chk_val("lost_sticky", lost_lock, 1);
        pulse_restart();
        chk_val("lost_cleared", lost_lock, 0);

        // No lock at all: four reset pulses of RST_CYC, then FAIL.
        locked_in = 2'b00;
        pulse_restart();
        run = (dll_rst == 2'b11) ? 1 : 0;
        pulses = 0;
        n = 0;
        while (!fail && n < 400) begin
            tick();
            n++;
            if (dll_rst == 2'b11) begin
                run++;
            end else if (run > 0) begin
                pulses++;
                chk_val("pulse_len", run, RST_CYC);
                run = 0;
            end
        end
        chk_val("pulse_count", pulses, MAX_RETRY + 1);
        chk_val("fail_reached", fail, 1);
        chk_val("fail_retry", retry_cnt, MAX_RETRY);
        chk_val("fail_dll_rst", dll_rst, 3);
        repeat (5) tick();
        pulse_restart();
        chk_val("fail_exit_state", state, S_RSTD);
        chk_val("fail_exit_retry", retry_cnt, 0);
        chk_val("fail_exit_fail", fail, 0);

        // Single channel enabled; disabled channel stays in reset.
        ch_en     = 2'b01;
        locked_in = 2'b01;
        repeat (40) tick();
        chk_val("ch1_held", dll_rst[1], 1);
        chk_val("ch0_locked", all_locked, 1);
        ch_en = 2'b00;
        tick();
        chk_val("hold_state", state, S_HOLD);
        chk_val("hold_dll_rst", dll_rst, 3);
        chk_val("hold_locked", all_locked, 0);

        // Lock arriving on the very timeout edge wins.
        ch_en     = 2'b11;
        locked_in = 2'b00;
        n = 0;
        while (state != S_WAIT && n < 20) begin
            tick();
            n++;
        end
        chk_val("reach_wait", state, S_WAIT);
        repeat (LOCK_TO - 3) tick();
        locked_in = 2'b11;
        repeat (3) tick();
        chk_val("lock_at_timeout", state, S_LOCK);
        chk_val("lock_at_to_retry", retry_cnt, 0);

        // Asynchronous reset in the middle of WAIT.
        locked_in = 2'b00;
        pulse_restart();
        repeat (RST_CYC + 5) tick();
        chk_val("mid_wait", state, S_WAIT);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk_val("async_state", state, S_RSTD);
        tick();
        rst = 1'b0;

        // Random stimulus against the model.
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 99) < 2) ch_en = 2'($urandom_range(0, 3));
            restart = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 4) begin
                if ($urandom_range(0, 2) == 0) locked_in = 2'($urandom_range(0, 3));
                else locked_in = ch_en;
            end
            tick();
        end
        restart = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
